// File: rtl/json_drive_streamer.sv
// Formats {type, left, right} drive commands into a 28-byte JSON frame and streams it over valid/ready.
// Optional idle heartbeat resend of the last frame: define DRIVE_HEARTBEAT_EN.
module json_drive_streamer #(
  parameter int SPEED_W          = 8,
  parameter int MAX_MAG          = 99,
  parameter int TYPE_W           = 4,
  parameter int SKIP_DUP         = 1,
  parameter int HEARTBEAT_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [TYPE_W-1:0]  cmd_type,
  input  logic [SPEED_W-1:0] left_speed,
  input  logic [SPEED_W-1:0] right_speed,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               overwrite,
  output logic [15:0]        frames_sent
);

  typedef struct packed {
    logic [3:0] t;
    logic       ln;
    logic [6:0] lm;
    logic       rn;
    logic [6:0] rm;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  // Widen by one bit before negating so the most-negative input cannot overflow.
  function automatic logic [7:0] sat_speed(input logic [SPEED_W-1:0] s);
    logic [SPEED_W:0] ext;
    logic [SPEED_W:0] mag;
    ext = {s[SPEED_W-1], s};
    mag = s[SPEED_W-1] ? -ext : ext;
    if (32'(mag) > MAX_MAG) sat_speed = {s[SPEED_W-1], 7'(MAX_MAG)};
    else                    sat_speed = {s[SPEED_W-1], 7'(mag)};
  endfunction

  state_t     state;
  cmd_t       cur, pend, last, cmd_in;
  logic       pend_valid, last_valid;
  logic [4:0] idx, idx_next;
  logic [3:0] l_tens, l_ones, r_tens, r_ones;
  logic [7:0] next_byte, ls, rs;
  logic       accept, is_dup;

  assign cmd_ready = !reset;
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign is_dup    = (SKIP_DUP != 0) && last_valid && (cmd_in == last);
  assign idx_next  = idx + 5'd1;

  always_comb begin
    ls        = sat_speed(left_speed);
    rs        = sat_speed(right_speed);
    cmd_in.t  = (32'(cmd_type) > 32'd9) ? 4'd9 : 4'(cmd_type);
    cmd_in.ln = ls[7];
    cmd_in.lm = ls[6:0];
    cmd_in.rn = rs[7];
    cmd_in.rm = rs[6:0];
  end

  always_comb begin
    next_byte = 8'h00;
    case (idx_next)
      5'd0:  next_byte = 8'h7B;
      5'd1, 5'd3, 5'd7, 5'd9, 5'd17, 5'd19: next_byte = 8'h22;
      5'd2:  next_byte = 8'h54;
      5'd4, 5'd10, 5'd20: next_byte = 8'h3A;
      5'd5:  next_byte = 8'h30 + {4'd0, cur.t};
      5'd6, 5'd16: next_byte = 8'h2C;
      5'd8:  next_byte = 8'h4C;
      5'd11: next_byte = cur.ln ? 8'h2D : 8'h30;
      5'd12, 5'd22: next_byte = 8'h30;
      5'd13, 5'd23: next_byte = 8'h2E;
      5'd14: next_byte = 8'h30 + {4'd0, l_tens};
      5'd15: next_byte = 8'h30 + {4'd0, l_ones};
      5'd18: next_byte = 8'h52;
      5'd21: next_byte = cur.rn ? 8'h2D : 8'h30;
      5'd24: next_byte = 8'h30 + {4'd0, r_tens};
      5'd25: next_byte = 8'h30 + {4'd0, r_ones};
      5'd26: next_byte = 8'h7D;
      5'd27: next_byte = 8'h0A;
      default: next_byte = 8'h00;
    endcase
  end

`ifdef DRIVE_HEARTBEAT_EN
  localparam int HB_W = $clog2(HEARTBEAT_CYCLES + 1);
  logic [HB_W-1:0] hb_cnt;
  logic            hb_fire;

  assign hb_fire = (state == IDLE) && last_valid && (32'(hb_cnt) == HEARTBEAT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (reset || state != IDLE || !last_valid || hb_fire || (accept && !is_dup)) hb_cnt <= '0;
    else hb_cnt <= hb_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cur         <= '0;
      pend        <= '0;
      last        <= '0;
      pend_valid  <= 1'b0;
      last_valid  <= 1'b0;
      idx         <= '0;
      l_tens      <= '0;
      l_ones      <= '0;
      r_tens      <= '0;
      r_ones      <= '0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      overwrite   <= 1'b0;
      frames_sent <= 16'd0;
    end else begin
      overwrite <= 1'b0;
      case (state)
        IDLE: begin
          tx_valid <= 1'b0;
          if (accept && !is_dup) begin
            cur   <= cmd_in;
            state <= LOAD;
          end
`ifdef DRIVE_HEARTBEAT_EN
          else if (hb_fire) begin
            cur   <= last;
            state <= LOAD;
          end
`endif
        end
        LOAD: begin
          l_tens   <= 4'(cur.lm / 7'd10);
          l_ones   <= 4'(cur.lm % 7'd10);
          r_tens   <= 4'(cur.rm / 7'd10);
          r_ones   <= 4'(cur.rm % 7'd10);
          idx      <= 5'd0;
          tx_valid <= 1'b1;
          tx_data  <= 8'h7B;
          state    <= SEND;
          if (accept) begin
            pend       <= cmd_in;
            pend_valid <= 1'b1;
            overwrite  <= pend_valid;
          end
        end
        default: begin
          if (accept) begin
            pend       <= cmd_in;
            pend_valid <= 1'b1;
            overwrite  <= pend_valid;
          end
          if (tx_ready) begin
            if (idx == 5'd27) begin
              frames_sent <= frames_sent + 16'd1;
              last        <= cur;
              last_valid  <= 1'b1;
              tx_valid    <= 1'b0;
              tx_data     <= 8'h00;
              // Pending is consumed here, so a same-cycle arrival refills it without an overwrite.
              if (pend_valid) begin
                cur       <= pend;
                state     <= LOAD;
                overwrite <= 1'b0;
                if (!accept) pend_valid <= 1'b0;
              end else if (accept) begin
                cur        <= cmd_in;
                pend_valid <= 1'b0;
                state      <= LOAD;
              end else begin
                state <= IDLE;
              end
            end else begin
              idx     <= idx_next;
              tx_data <= next_byte;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_json_drive_streamer.sv
// Directed bench for json_drive_streamer: table of frames plus stall, overwrite, dup and reset sequences.
module tb_json_drive_streamer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_type = 4'd0;
  logic [7:0] left_speed = 8'd0;
  logic [7:0] right_speed = 8'd0;
  logic       tx_ready = 1'b1;
  logic       cmd_ready, tx_valid, busy, overwrite;
  logic [7:0] tx_data;
  logic [15:0] frames_sent;
  logic       cmd_ready_n, tx_valid_n, busy_n, overwrite_n;
  logic [7:0] tx_data_n;
  logic [15:0] frames_sent_n;

  json_drive_streamer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .left_speed(left_speed), .right_speed(right_speed),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overwrite(overwrite), .frames_sent(frames_sent)
  );

  json_drive_streamer #(.SKIP_DUP(0)) dut_nodup (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_n),
    .cmd_type(cmd_type), .left_speed(left_speed), .right_speed(right_speed),
    .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready),
    .busy(busy_n), .overwrite(overwrite_n), .frames_sent(frames_sent_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] t;
    logic [7:0] l;
    logic [7:0] r;
    string      exp;
  } vec_t;

  vec_t       vecs[6];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         ov_cnt = 0;
  bit         stall_mode = 1'b0;
  logic [7:0] rx_q[$];
  int         hs_cyc[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Byte collector and stall-stability monitor, sampled on the falling edge.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (prev_stall && !reset) begin
        checks++;
        if (!tx_valid || tx_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold actual valid=%0b data=%02h required valid=1 data=%02h",
                   tx_valid, tx_data, prev_data);
        end
      end
      prev_stall = tx_valid && !tx_ready && !reset;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) begin
        rx_q.push_back(tx_data);
        hs_cyc.push_back(cyc);
      end
      if (overwrite) ov_cnt++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] t, input logic [7:0] l, input logic [7:0] r);
    cmd_type    = t;
    left_speed  = l;
    right_speed = r;
    cmd_valid   = 1'b1;
    tick();
    cmd_valid   = 1'b0;
  endtask

  task automatic wait_frames(input int tgt, input int budget);
    int n;
    n = 0;
    while (frames_sent != 16'(tgt) && n < budget) begin
      tick();
      n++;
    end
    chk("frames_sent_wait", 32'(frames_sent), 32'(tgt));
  endtask

  task automatic check_frame(input string name, input string exp);
    int bad;
    bad = -1;
    checks++;
    for (int i = 0; i < exp.len() && i < rx_q.size(); i++)
      if (bad < 0 && rx_q[i] !== 8'(exp.getc(i))) bad = i;
    if (rx_q.size() != exp.len() || bad >= 0) begin
      errors++;
      if (bad >= 0)
        $display("FAIL %s len=%0d/%0d byte %0d actual=%02h required=%02h",
                 name, rx_q.size(), exp.len(), bad, rx_q[bad], 8'(exp.getc(bad)));
      else
        $display("FAIL %s length actual=%0d required=%0d", name, rx_q.size(), exp.len());
    end else begin
      $display("frame %s ok: %s", name, exp.substr(0, exp.len() - 2));
    end
  endtask

  initial begin
    int    exp_frames;
    int    n;
    string fa, fc, fd, fe;
    vecs[0] = '{4'd1,  8'(-10),  8'd10,    "{\"T\":1,\"L\":-0.10,\"R\":00.10}\n"};
    vecs[1] = '{4'd12, 8'h80,    8'd127,   "{\"T\":9,\"L\":-0.99,\"R\":00.99}\n"};
    vecs[2] = '{4'd0,  8'd0,     8'(-5),   "{\"T\":0,\"L\":00.00,\"R\":-0.05}\n"};
    vecs[3] = '{4'd9,  8'd30,    8'd99,    "{\"T\":9,\"L\":00.30,\"R\":00.99}\n"};
    vecs[4] = '{4'd15, 8'd100,   8'(-99),  "{\"T\":9,\"L\":00.99,\"R\":-0.99}\n"};
    vecs[5] = '{4'd3,  8'(-1),   8'd1,     "{\"T\":3,\"L\":-0.01,\"R\":00.01}\n"};
    fa = "{\"T\":4,\"L\":00.20,\"R\":00.20}\n";
    fc = "{\"T\":6,\"L\":00.07,\"R\":-0.07}\n";
    fd = "{\"T\":7,\"L\":00.11,\"R\":00.22}\n";
    fe = "{\"T\":8,\"L\":-0.33,\"R\":00.44}\n";

    repeat (3) tick();
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overwrite", 32'(overwrite), 0);
    chk("rst_frames", 32'(frames_sent), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    reset = 1'b0;
    tick();
    chk("cmd_ready_run", 32'(cmd_ready), 1);

    exp_frames = 0;
    for (int i = 0; i < 6; i++) begin
      rx_q.delete();
      send(vecs[i].t, vecs[i].l, vecs[i].r);
      chk("load_busy", 32'(busy), 1);
      chk("load_no_valid", 32'(tx_valid), 0);
      tick();
      chk("byte0_valid", 32'(tx_valid), 1);
      chk("byte0_data", 32'(tx_data), 32'h7B);
      exp_frames++;
      wait_frames(exp_frames, 60);
      check_frame($sformatf("vec%0d", i), vecs[i].exp);
      repeat (3) tick();
    end

    // Random backpressure.
    rx_q.delete();
    stall_mode = 1'b1;
    send(4'd2, 8'd45, 8'(-67));
    exp_frames++;
    wait_frames(exp_frames, 600);
    stall_mode = 1'b0;
    check_frame("stall", "{\"T\":2,\"L\":00.45,\"R\":-0.67}\n");
    repeat (3) tick();

    // A, then B and C mid-frame: C replaces B.
    rx_q.delete();
    hs_cyc.delete();
    ov_cnt = 0;
    send(4'd4, 8'd20, 8'd20);
    repeat (5) tick();
    send(4'd5, 8'(-50), 8'd50);
    send(4'd6, 8'd7, 8'(-7));
    exp_frames += 2;
    wait_frames(exp_frames, 150);
    check_frame("a_then_c", {fa, fc});
    chk("overwrite_pulses", 32'(ov_cnt), 1);
    if (hs_cyc.size() >= 29) chk("load_bubble", 32'(hs_cyc[28] - hs_cyc[27]), 2);
    else chk("load_bubble_bytes", 32'(hs_cyc.size()), 56);
    repeat (40) tick();
    chk("b_never_sent", 32'(frames_sent), 32'(exp_frames));

    // Duplicate suppression only on the SKIP_DUP=1 instance.
    chk("nodup_sync", 32'(frames_sent_n), 32'(exp_frames));
    rx_q.delete();
    send(4'd7, 8'd11, 8'd22);
    exp_frames++;
    wait_frames(exp_frames, 60);
    check_frame("dup_first", fd);
    repeat (5) tick();
    send(4'd7, 8'd11, 8'd22);
    repeat (60) tick();
    chk("dup_skipped", 32'(frames_sent), 32'(exp_frames));
    chk("dup_idle", 32'(busy), 0);
    chk("nodup_two_frames", 32'(frames_sent_n), 32'(exp_frames + 1));

    // Reset in the middle of a frame.
    rx_q.delete();
    send(4'd8, 8'(-33), 8'd44);
    n = 0;
    while (rx_q.size() < 13 && n < 100) begin
      tick();
      n++;
    end
    chk("reach_byte13", 32'(rx_q.size() >= 13), 1);
    reset = 1'b1;
    tick();
    chk("midrst_tx_valid", 32'(tx_valid), 0);
    chk("midrst_frames", 32'(frames_sent), 0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 0);
    reset = 1'b0;
    tick();
    rx_q.delete();
    send(4'd8, 8'(-33), 8'd44);
    wait_frames(1, 60);
    check_frame("after_reset", fe);
    chk("nodup_after_reset", 32'(frames_sent_n), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/json_drive_streamer.md
Name: json_drive_streamer

Overview:
- Parametrised successor to the fixed-table motor command generator.
- Accepts a command type plus signed left/right wheel speeds in hundredths, then formats them at run time into the 28-byte JSON drive frame `{"T":t,"L":s0.dd,"R":s0.dd}\n`.
- Streams the frame byte-by-byte to the UART transmitter over a valid/ready handshake.
- Holds a one-deep latest-wins pending command, so updates arriving mid-frame are not lost.
- Sits between the gesture/difficulty decision logic and the UART TX.

Parameters:
- SPEED_W, 8: width of the signed two's-complement speed inputs.
- MAX_MAG, 99: speed magnitude saturation limit in hundredths; legal range 1..99.
- TYPE_W, 4: width of the cmd_type input.
- SKIP_DUP, 1: when 1, a command identical to the last one sent while idle produces no frame.
- HEARTBEAT_CYCLES, 50000000: idle resend period in clocks; used only with DRIVE_HEARTBEAT_EN.

Ports:
- clk, input, 1: system clock; single clock domain.
- reset, input, 1: synchronous, active-high reset.
- cmd_valid, input, 1: command offer.
- cmd_ready, output, 1: command accept; low only during reset.
- cmd_type, input, TYPE_W: value for the T field; values above 9 saturate to 9.
- left_speed, input, SPEED_W: signed, hundredths.
- right_speed, input, SPEED_W: signed, hundredths.
- tx_data, output, 8: ASCII byte to the UART.
- tx_valid, output, 1: tx_data is valid.
- tx_ready, input, 1: UART accepts the byte.
- busy, output, 1: high in LOAD or SEND.
- overwrite, output, 1: one-cycle pulse when a pending command is replaced.
- frames_sent, output, 16: wrapping count of completed frames.

Behaviour:
- Reset values: tx_valid=0, tx_data=0, busy=0, overwrite=0, frames_sent=0, cmd_ready=0 while reset is asserted. All internal registers clear: pending, last-sent-valid, byte index, heartbeat counter.
- Handshake: a command is accepted on cmd_valid && cmd_ready. cmd_ready is 1 in every cycle reset is low.
- Saturation at capture:
  - Magnitude = |speed| clamped to MAX_MAG.
  - The most-negative input saturates to MAX_MAG without overflow.
  - Sign is negative only if speed<0.
- Digit formation: tens = mag/10, ones = mag%10, computed in LOAD and registered.
- Byte map, indices 0..27:
  - 0 '{', 1 '"', 2 'T', 3 '"', 4 ':', 5 '0'+type, 6 ',', 7 '"', 8 'L', 9 '"', 10 ':'.
  - 11-15 left field, 16 ',', 17 '"', 18 'R', 19 '"', 20 ':'.
  - 21-25 right field, 26 '}', 27 0x0A.
- Speed field (5 bytes): sign char ('-' 0x2D if negative, else '0' 0x30), then '0', '.', '0'+tens, '0'+ones. Example: -5 gives "-0.05"; 30 gives "00.30"; 0 gives "00.00".
- State machine: IDLE, LOAD, SEND.
  - IDLE: an accepted command moves to LOAD, except a duplicate (see SKIP_DUP below), which stays in IDLE.
  - LOAD: one cycle; latch formatted fields, index=0, move to SEND.
  - SEND: tx_valid=1 and tx_data = byte[index]. tx_data and tx_valid stay stable while tx_ready=0. Each handshake increments index.
  - End of SEND: the handshake on index 27 increments frames_sent (mod 2^16) and records the frame as last-sent. Go to LOAD if pending is valid (consuming pending), else IDLE.
- Latency: command accepted in IDLE at cycle N gives byte 0 valid at N+2. With tx_ready held at 1, one frame takes 28 cycles. Back-to-back frames have exactly one LOAD bubble.
- Command accepted during LOAD or SEND: written to pending.
  - If pending was already valid, it is overwritten and overwrite pulses.
  - A command accepted in the same cycle as the index-27 handshake goes to pending and is sent next.
- SKIP_DUP=1: the dup check compares saturated type/sign/magnitudes against last-sent, and applies in IDLE only. Pending commands are never suppressed.
- tx_ready asserted while tx_valid=0 is ignored.
- Reset mid-frame: tx_valid=0 in the first cycle after reset. The partial frame is abandoned and not counted; the next frame restarts at '{'.

Optional Feature:
- Macro: DRIVE_HEARTBEAT_EN.
- Defined:
  - A counter runs while in IDLE with last-sent valid, and clears on entry to LOAD.
  - On reaching HEARTBEAT_CYCLES-1, the block re-enters LOAD with the last-sent command, bypassing SKIP_DUP. This keeps the robot's watchdog fed.
  - A new command arriving in the same cycle takes priority over the heartbeat.
- Undefined: no counter logic, and no frame is ever generated without a command.

Test Plan:
- Type=1, L=-10, R=10, tx_ready=1 -> 28 bytes `{"T":1,"L":-0.10,"R":00.10}\n`, byte 0 at acceptance+2, frames_sent=1.
- L=-128, R=127 (SPEED_W=8) -> L field "-0.99", R field "00.99"; type=12 -> T byte '9'.
- Toggle tx_ready pseudo-randomly 50% -> bytes in order with no drops or duplicates, tx_data stable while stalled.
- Commands A, B, C offered mid-frame -> A's frame completes, overwrite pulses once (C replaces B), C's frame follows after one LOAD cycle, B is never sent.
- Same command twice with idle in between and SKIP_DUP=1 -> a single frame; with SKIP_DUP=0 -> two identical frames.
- Reset asserted at byte 13 -> tx_valid=0 the next cycle, frames_sent=0; the next command starts at '{'. With DRIVE_HEARTBEAT_EN and HEARTBEAT_CYCLES=100, an idle resend starts 100 cycles after the last frame.
